// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4-to-1 mux
// Grants one requester at a time, bounds each grant to BURST cycles, gates the mux output.

module mux4_gate (
  input  logic [3:0] d,
  input  logic       s1,
  input  logic       s0,
  output logic       y
);
  assign y = (d[0] & ~s1 & ~s0) |
             (d[1] & ~s1 &  s0) |
             (d[2] &  s1 & ~s0) |
             (d[3] &  s1 &  s0);
endmodule

module mux4_rr_arbiter #(
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       o
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [2:0]      win, win_rel;
  logic [1:0]      rel_ptr;
  logic            mux_y;

  // Returns {found, index}; the lowest offset from p wins, wrapping mod 4.
  function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      j = p + 2'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rel_ptr = idx_q + 2'd1;
    win     = find_winner(req, ptr_q);
    win_rel = find_winner(req, rel_ptr);
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win[2]) begin
          state_d = GRANT;
          idx_d   = win[1:0];
          sel_d   = win[1:0];
          gnt_d   = 4'b0001 << win[1:0];
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (req[idx_q] && (cnt_q < CW'(BURST))) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Release: pointer moves past the holder, then re-arbitrate on the same edge.
          ptr_d = rel_ptr;
          if (win_rel[2]) begin
            idx_d = win_rel[1:0];
            sel_d = win_rel[1:0];
            gnt_d = 4'b0001 << win_rel[1:0];
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  mux4_gate u_mux (
    .d  (d),
    .s1 (sel_q[1]),
    .s0 (sel_q[0]),
    .y  (mux_y)
  );

  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign gnt   = gnt_q;
  assign valid = (state_q == GRANT);
  assign o     = mux_y & valid;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
// Instance 0 uses BURST=4, instance 1 uses BURST=2; both are checked against a queue-free model.

module tb_mux4_rr_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req_v   [2];
  logic [3:0] d_v     [2];
  logic [3:0] gnt_v   [2];
  logic       s1_v    [2];
  logic       s0_v    [2];
  logic       valid_v [2];
  logic       o_v     [2];

  int passed;
  int total;

  int m_hold [2];
  int m_cnt  [2];
  int m_ptr  [2];
  int m_sel  [2];
  int burst  [2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;
  } vec_t;

  vec_t vt [8];

  mux4_rr_arbiter #(.BURST(4), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v[0]),
    .d     (d_v[0]),
    .s1    (s1_v[0]),
    .s0    (s0_v[0]),
    .gnt   (gnt_v[0]),
    .valid (valid_v[0]),
    .o     (o_v[0])
  );

  mux4_rr_arbiter #(.BURST(2), .CW(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v[1]),
    .d     (d_v[1]),
    .s1    (s1_v[1]),
    .s0    (s0_v[1]),
    .gnt   (gnt_v[1]),
    .valid (valid_v[1]),
    .o     (o_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int find_first(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = -1;
      m_cnt[i]  = 0;
      m_ptr[i]  = 0;
      m_sel[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] r);
    int w;
    if (m_hold[i] < 0) begin
      w = find_first(r, m_ptr[i]);
      if (w >= 0) begin
        m_hold[i] = w; m_cnt[i] = 1; m_sel[i] = w;
      end
    end else if (r[m_hold[i]] && m_cnt[i] < burst[i]) begin
      m_cnt[i]++;
    end else begin
      m_ptr[i] = (m_hold[i] + 1) % 4;
      w = find_first(r, m_ptr[i]);
      if (w >= 0) begin
        m_hold[i] = w; m_cnt[i] = 1; m_sel[i] = w;
      end else begin
        m_hold[i] = -1;
      end
    end
  endtask

  task automatic check_model(input int i);
    int eg;
    int ev;
    eg = (m_hold[i] < 0) ? 0 : (1 << m_hold[i]);
    ev = (m_hold[i] < 0) ? 0 : 1;
    chk($sformatf("model_gnt%0d", i), int'(gnt_v[i]), eg);
    chk($sformatf("model_sel%0d", i), int'({s1_v[i], s0_v[i]}), m_sel[i]);
    chk($sformatf("model_valid%0d", i), int'(valid_v[i]), ev);
    chk($sformatf("model_o%0d", i), int'(o_v[i]), ev & int'(d_v[i][m_sel[i]]));
  endtask

  task automatic tick(input logic [3:0] r0, input logic [3:0] dd0,
                      input logic [3:0] r1, input logic [3:0] dd1);
    @(negedge clk);
    req_v[0] = r0; d_v[0] = dd0;
    req_v[1] = r1; d_v[1] = dd1;
    @(posedge clk);
    model_step(0, r0);
    model_step(1, r1);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_v[0] = 4'b0000; req_v[1] = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r0;
    logic [3:0] r1;
    passed = 0;
    total  = 0;
    burst[0] = 4;
    burst[1] = 2;

    vt[0] = '{req: 4'b0010, d: 4'b0000, gnt: 4'b0010, sel: 2'b01, valid: 1'b1, o: 1'b0};
    vt[1] = '{req: 4'b0010, d: 4'b0010, gnt: 4'b0010, sel: 2'b01, valid: 1'b1, o: 1'b1};
    vt[2] = '{req: 4'b0000, d: 4'b1111, gnt: 4'b0000, sel: 2'b01, valid: 1'b0, o: 1'b0};
    vt[3] = '{req: 4'b1001, d: 4'b1000, gnt: 4'b1000, sel: 2'b11, valid: 1'b1, o: 1'b1};
    vt[4] = '{req: 4'b1001, d: 4'b0111, gnt: 4'b1000, sel: 2'b11, valid: 1'b1, o: 1'b0};
    vt[5] = '{req: 4'b0001, d: 4'b0001, gnt: 4'b0001, sel: 2'b00, valid: 1'b1, o: 1'b1};
    vt[6] = '{req: 4'b0000, d: 4'b1111, gnt: 4'b0000, sel: 2'b00, valid: 1'b0, o: 1'b0};
    vt[7] = '{req: 4'b0001, d: 4'b0001, gnt: 4'b0001, sel: 2'b00, valid: 1'b1, o: 1'b1};

    // Power-up reset, checked before any clock edge.
    rst_n = 1'b0;
    req_v[0] = 4'b0000; req_v[1] = 4'b0000;
    d_v[0] = 4'b1111; d_v[1] = 4'b1111;
    model_reset();
    #2;
    chk("por_gnt", int'(gnt_v[0]), 0);
    chk("por_sel", int'({s1_v[0], s0_v[0]}), 0);
    chk("por_valid", int'(valid_v[0]), 0);
    chk("por_o", int'(o_v[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Drop to idle, pointer advance, and o gating.
    for (int v = 0; v < 8; v++) begin
      tick(vt[v].req, vt[v].d, 4'b0000, 4'b0000);
      chk($sformatf("vec%0d_gnt", v), int'(gnt_v[0]), int'(vt[v].gnt));
      chk($sformatf("vec%0d_sel", v), int'({s1_v[0], s0_v[0]}), int'(vt[v].sel));
      chk($sformatf("vec%0d_valid", v), int'(valid_v[0]), int'(vt[v].valid));
      chk($sformatf("vec%0d_o", v), int'(o_v[0]), int'(vt[v].o));
    end

    // Async reset mid-grant, no clock edge.
    tick(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_gnt", int'(gnt_v[0]), 0);
    chk("arst_sel", int'({s1_v[0], s0_v[0]}), 0);
    chk("arst_valid", int'(valid_v[0]), 0);
    chk("arst_o", int'(o_v[0]), 0);
    chk("arst_gnt2", int'(gnt_v[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    chk("post_rst_first", int'(gnt_v[0]), 1);

    // Single requester held: re-granted at each expiry with no valid gap.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick(4'b0100, (c % 2 == 0) ? 4'b0100 : 4'b1011, 4'b0000, 4'b0000);
      chk("solo_gnt", int'(gnt_v[0]), 4);
      chk("solo_valid", int'(valid_v[0]), 1);
      chk("solo_o", int'(o_v[0]), (c % 2 == 0) ? 1 : 0);
    end

    // Full load rotation, each holder keeps 4 cycles.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(4'b1111, 4'b0000, 4'b1111, 4'b0000);
      chk("rot_gnt", int'(gnt_v[0]), 1 << ((c / 4) % 4));
      chk("rot_sel", int'({s1_v[0], s0_v[0]}), (c / 4) % 4);
      chk("rot2_gnt", int'(gnt_v[1]), 1 << ((c / 2) % 4));
    end

    // BURST=2: drop and expiry coincide, single pointer advance.
    do_reset();
    tick(4'b0000, 4'b0000, 4'b0011, 4'b0000);
    chk("b2_e1", int'(gnt_v[1]), 1);
    tick(4'b0000, 4'b0000, 4'b0011, 4'b0000);
    chk("b2_e2", int'(gnt_v[1]), 1);
    tick(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    chk("b2_e3", int'(gnt_v[1]), 2);
    tick(4'b0000, 4'b0000, 4'b0011, 4'b0000);
    chk("b2_e4", int'(gnt_v[1]), 2);
    tick(4'b0000, 4'b0000, 4'b0011, 4'b0000);
    chk("b2_e5", int'(gnt_v[1]), 1);

    // Randomized traffic with sticky requests to exercise long bursts.
    do_reset();
    r0 = 4'b0000;
    r1 = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r0 = 4'($urandom);
      if ($urandom_range(0, 2) == 0) r1 = 4'($urandom);
      tick(r0, 4'($urandom), r1, 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
